// File: rtl/pip_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, control bundle, register constants.
package pip_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned FLUSH_CW   = 3;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    HZ_RUN       = 1'b0,
    HZ_DMEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_we;
    logic fd_we;
    logic de_we;
    logic em_we;
    logic mw_we;
    logic fd_bubble;
    logic de_bubble;
    logic mw_bubble;
    logic imem_kill;
  } hz_ctrl_t;

  // Free-running pipeline: every register advances, nothing squashed.
  localparam hz_ctrl_t HZ_CTRL_RUN = '{
    pc_we:     1'b1,
    fd_we:     1'b1,
    de_we:     1'b1,
    em_we:     1'b1,
    mw_we:     1'b1,
    fd_bubble: 1'b0,
    de_bubble: 1'b0,
    mw_bubble: 1'b0,
    imem_kill: 1'b0
  };

endpackage

// File: rtl/pip_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Pipeline hazard control: register enables, bubble selects, stale-fetch discard and perf counters.
module pip_hazard_ctrl
  import pip_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FLUSH_RESP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic                 i_ex_valid,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_ex_is_load,
  input  logic                 i_ex_redirect,
  input  logic                 i_imem_valid,
  input  logic                 i_mem_req,
  input  logic                 i_dmem_ready,
  output logic                 o_pc_write_en,
  output logic                 o_fet_dec_write_en,
  output logic                 o_dec_exe_write_en,
  output logic                 o_exe_mem_write_en,
  output logic                 o_mem_wb_write_en,
  output logic                 o_fet_dec_bubble,
  output logic                 o_dec_exe_bubble,
  output logic                 o_mem_wb_bubble,
  output logic                 o_imem_kill,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt
);

  localparam logic [FLUSH_CW-1:0] FLUSH_LOAD = FLUSH_CW'(FLUSH_RESP);

  hz_state_t           state, state_nxt;
  logic [FLUSH_CW-1:0] flush_left, flush_nxt;
  hz_ctrl_t            ctrl;
  logic                flush_inc;
  logic                stall_inc;

  logic dmem_stall, redirect, rs1_hit, rs2_hit, load_use, stale_fetch;

  assign dmem_stall  = i_mem_req && !i_dmem_ready;
  assign redirect    = i_ex_valid && i_ex_redirect;
  assign rs1_hit     = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
  assign rs2_hit     = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
  assign load_use    = i_ex_valid && i_ex_is_load && (i_ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);
  assign stale_fetch = (flush_left != '0) && i_imem_valid;

  // State and discard-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HZ_RUN;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_nxt;
    end
  end

  // Next-state and prioritised control decode; earlier hazards freeze later ones
  always_comb begin
    ctrl      = HZ_CTRL_RUN;
    state_nxt = state;
    flush_nxt = flush_left;
    flush_inc = 1'b0;

    unique case (state)
      HZ_RUN:       if (dmem_stall)  state_nxt = HZ_DMEM_WAIT;
      HZ_DMEM_WAIT: if (!dmem_stall) state_nxt = HZ_RUN;
      default:      state_nxt = HZ_RUN;
    endcase

    if (dmem_stall) begin
      ctrl.pc_we     = 1'b0;
      ctrl.fd_we     = 1'b0;
      ctrl.de_we     = 1'b0;
      ctrl.em_we     = 1'b0;
      ctrl.mw_bubble = 1'b1;
    end else if (redirect) begin
      ctrl.fd_bubble = 1'b1;
      ctrl.de_bubble = 1'b1;
      flush_nxt      = FLUSH_LOAD;
      flush_inc      = 1'b1;
    end else if (load_use) begin
      ctrl.pc_we     = 1'b0;
      ctrl.fd_we     = 1'b0;
      ctrl.de_bubble = 1'b1;
    end else if (stale_fetch) begin
      ctrl.imem_kill = 1'b1;
      ctrl.pc_we     = 1'b0;
      ctrl.fd_bubble = 1'b1;
      flush_nxt      = flush_left - FLUSH_CW'(1);
    end else if (!i_imem_valid) begin
      ctrl.pc_we     = 1'b0;
      ctrl.fd_bubble = 1'b1;
    end

    if (rst) begin
      ctrl      = '0;
      flush_inc = 1'b0;
    end
  end

  assign stall_inc = !rst && !ctrl.pc_we;

  assign o_pc_write_en      = ctrl.pc_we;
  assign o_fet_dec_write_en = ctrl.fd_we;
  assign o_dec_exe_write_en = ctrl.de_we;
  assign o_exe_mem_write_en = ctrl.em_we;
  assign o_mem_wb_write_en  = ctrl.mw_we;
  assign o_fet_dec_bubble   = ctrl.fd_bubble;
  assign o_dec_exe_bubble   = ctrl.de_bubble;
  assign o_mem_wb_bubble    = ctrl.mw_bubble;
  assign o_imem_kill        = ctrl.imem_kill;

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (stall_inc),
    .cnt (o_stall_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (flush_inc),
    .cnt (o_flush_cnt)
  );

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Directed bench for pip_hazard_ctrl with hand-computed control vectors and counter values.
module tb_pip_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // Control vector order: {pc, fd, de, em, mw, fd_bub, de_bub, mw_bub, kill}
  localparam logic [8:0] V_RST   = 9'b00000_000_0;
  localparam logic [8:0] V_RUN   = 9'b11111_000_0;
  localparam logic [8:0] V_LDUSE = 9'b00111_010_0;
  localparam logic [8:0] V_DMEM  = 9'b00001_001_0;
  localparam logic [8:0] V_REDIR = 9'b11111_110_0;
  localparam logic [8:0] V_KILL  = 9'b01111_100_1;
  localparam logic [8:0] V_IWAIT = 9'b01111_100_0;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_valid, ex_is_load, ex_redirect;
  logic imem_valid, mem_req, dmem_ready;
  logic pc_we, fd_we, de_we, em_we, mw_we, fd_bub, de_bub, mw_bub, imem_kill;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] vec;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign vec = {pc_we, fd_we, de_we, em_we, mw_we, fd_bub, de_bub, mw_bub, imem_kill};

  pip_hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_RESP(1)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_id_rs1           (id_rs1),
    .i_id_rs2           (id_rs2),
    .i_id_rs1_used      (id_rs1_used),
    .i_id_rs2_used      (id_rs2_used),
    .i_ex_valid         (ex_valid),
    .i_ex_rd            (ex_rd),
    .i_ex_is_load       (ex_is_load),
    .i_ex_redirect      (ex_redirect),
    .i_imem_valid       (imem_valid),
    .i_mem_req          (mem_req),
    .i_dmem_ready       (dmem_ready),
    .o_pc_write_en      (pc_we),
    .o_fet_dec_write_en (fd_we),
    .o_dec_exe_write_en (de_we),
    .o_exe_mem_write_en (em_we),
    .o_mem_wb_write_en  (mw_we),
    .o_fet_dec_bubble   (fd_bub),
    .o_dec_exe_bubble   (de_bub),
    .o_mem_wb_bubble    (mw_bub),
    .o_imem_kill        (imem_kill),
    .o_stall_cnt        (stall_cnt),
    .o_flush_cnt        (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    imem_valid = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Apply inputs after the falling edge, sample once combinational outputs settle.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc(); settle();
    chk("rst_outputs", 32'(vec), 32'(V_RST));
    cyc();
    rst = 1'b0; settle();
    chk("run_vec", 32'(vec), 32'(V_RUN));
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Load-use on rs1
    cyc();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    settle();
    chk("lduse_rs1", 32'(vec), 32'(V_LDUSE));
    cyc(); idle(); settle();
    chk("lduse_after", 32'(vec), 32'(V_RUN));
    chk("lduse_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load to x0 never stalls
    cyc();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    settle();
    chk("lduse_x0", 32'(vec), 32'(V_RUN));

    // rs2 match counts only when rs2 is used
    cyc(); idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    settle();
    chk("lduse_rs2_unused", 32'(vec), 32'(V_RUN));
    id_rs2_used = 1'b1; settle();
    chk("lduse_rs2", 32'(vec), 32'(V_LDUSE));
    cyc(); idle(); settle();
    chk("lduse2_stall_cnt", 32'(stall_cnt), 32'd2);

    // Reset, then a 3-cycle dmem stall
    rst = 1'b1; cyc(); rst = 1'b0; settle();
    chk("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; dmem_ready = 1'b0; settle();
      chk("dmem_stall", 32'(vec), 32'(V_DMEM));
      cyc();
    end
    dmem_ready = 1'b1; settle();
    chk("dmem_release", 32'(vec), 32'(V_RUN));
    chk("dmem_stall_cnt", 32'(stall_cnt), 32'd3);
    cyc(); idle(); settle();
    chk("dmem_stall_cnt_hold", 32'(stall_cnt), 32'd3);

    // Redirect then stale response killed, next accepted
    ex_valid = 1'b1; ex_redirect = 1'b1; settle();
    chk("redirect", 32'(vec), 32'(V_REDIR));
    cyc(); idle(); settle();
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("stale_kill", 32'(vec), 32'(V_KILL));
    cyc(); settle();
    chk("after_kill", 32'(vec), 32'(V_RUN));
    chk("kill_stall_cnt", 32'(stall_cnt), 32'd4);

    // Discard count held across an imem wait cycle
    ex_valid = 1'b1; ex_redirect = 1'b1; settle();
    cyc(); idle(); imem_valid = 1'b0; settle();
    chk("flush_imem_wait", 32'(vec), 32'(V_IWAIT));
    cyc(); imem_valid = 1'b1; settle();
    chk("flush_kill_late", 32'(vec), 32'(V_KILL));
    cyc(); settle();
    chk("flush_done", 32'(vec), 32'(V_RUN));
    chk("flush_cnt_2", 32'(flush_cnt), 32'd2);

    // Redirect concurrent with dmem stall: stall wins, redirect lands on release
    ex_valid = 1'b1; ex_redirect = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0; settle();
    chk("redir_vs_dmem", 32'(vec), 32'(V_DMEM));
    cyc(); settle();
    chk("redir_vs_dmem_cnt", 32'(flush_cnt), 32'd2);
    dmem_ready = 1'b1; settle();
    chk("redir_on_release", 32'(vec), 32'(V_REDIR));
    cyc(); idle(); settle();
    chk("redir_release_cnt", 32'(flush_cnt), 32'd3);
    chk("redir_release_kill", 32'(vec), 32'(V_KILL));
    cyc(); settle();

    // Stall counter saturates at 15
    imem_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (i == 10) chk("imem_wait", 32'(vec), 32'(V_IWAIT));
      cyc();
    end
    imem_valid = 1'b1; settle();
    chk("stall_sat", 32'(stall_cnt), 32'd15);

    // Reset during DMEM_WAIT
    mem_req = 1'b1; dmem_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b1; settle();
    chk("rst_in_dmem", 32'(vec), 32'(V_RST));
    cyc(); rst = 1'b0; idle(); settle();
    chk("rst_dmem_vec", 32'(vec), 32'(V_RUN));
    chk("rst_dmem_stall", 32'(stall_cnt), 32'd0);
    chk("rst_dmem_flush", 32'(flush_cnt), 32'd0);

    // Reset mid-flush clears the pending discard
    ex_valid = 1'b1; ex_redirect = 1'b1; settle();
    cyc(); idle(); rst = 1'b1; settle();
    cyc(); rst = 1'b0; settle();
    chk("rst_mid_flush", 32'(vec), 32'(V_RUN));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
